// File: rtl/sdram_cache_pkg.sv
// -----------------------------------------------------------------------------
// sdram_cache_pkg
// Shared definitions for the SDRAM word cache:
//   - cache_state_e : controller state encoding
//   - tag_of()      : tag field of a byte address (right-justified)
//   - index_of()    : line index of a byte address (right-justified)
// The field helpers take the index width as an argument, so they serve any
// cache geometry whose address fits in MAX_ADDR_WIDTH bits. Callers truncate
// the right-justified result to their own field width.
// -----------------------------------------------------------------------------
package sdram_cache_pkg;

  localparam int MAX_ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_SWEEP    = 3'd0,  // post-reset invalidation of every line
    ST_FLUSH    = 3'd1,  // flush-requested invalidation of every line
    ST_IDLE     = 3'd2,
    ST_LOOKUP   = 3'd3,  // RAM outputs valid, hit/miss decided
    ST_RD_ISSUE = 3'd4,  // mem_rd pulse on the bus
    ST_RD_WAIT  = 3'd5,
    ST_WR_ISSUE = 3'd6,  // mem_wmask pulse on the bus
    ST_WR_WAIT  = 3'd7
  } cache_state_e;

  // Tag = everything above the index and the two byte-offset bits.
  function automatic logic [MAX_ADDR_WIDTH-1:0] tag_of(
    input logic [MAX_ADDR_WIDTH-1:0] a,
    input int unsigned               index_bits
  );
    return a >> (index_bits + 2);
  endfunction

  // Index = the index_bits word-address bits just above the byte offset.
  function automatic logic [MAX_ADDR_WIDTH-1:0] index_of(
    input logic [MAX_ADDR_WIDTH-1:0] a,
    input int unsigned               index_bits
  );
    logic [MAX_ADDR_WIDTH-1:0] mask;
    mask = (MAX_ADDR_WIDTH'(1) << index_bits) - MAX_ADDR_WIDTH'(1);
    return (a >> 2) & mask;
  endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// -----------------------------------------------------------------------------
// sdram_cache_ram
// Simple dual-port RAM with synchronous (registered) read and per-lane write
// enables. Each lane is its own array so the tools can map it to block RAM.
// Read of an address being written in the same cycle returns the old data.
// Ports:
//   clk_i    clock
//   we_i     per-lane write enable
//   waddr_i  write address
//   wdata_i  write data, lane gi at bits [gi*LANE_W +: LANE_W]
//   raddr_i  read address (sampled every cycle)
//   rdata_o  read data, one cycle after raddr_i
// -----------------------------------------------------------------------------
module sdram_cache_ram #(
  parameter int LANE_W    = 8,
  parameter int LANES     = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                      clk_i,
  input  logic [LANES-1:0]          we_i,
  input  logic [ADDR_BITS-1:0]      waddr_i,
  input  logic [LANES*LANE_W-1:0]   wdata_i,
  input  logic [ADDR_BITS-1:0]      raddr_i,
  output logic [LANES*LANE_W-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] ram [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (we_i[gi]) begin
        ram[waddr_i] <= wdata_i[gi*LANE_W +: LANE_W];
      end
      rdata_q <= ram[raddr_i];
    end

    assign rdata_o[gi*LANE_W +: LANE_W] = rdata_q;
  end

endmodule

// File: rtl/sdram_cache.sv
// -----------------------------------------------------------------------------
// sdram_cache
// Direct-mapped, write-through, no-write-allocate cache of 32-bit words that
// sits between the CPU bus and the SDRAM controller. Both sides use the same
// handshake: one-cycle rd/wmask pulse, address/data held until busy falls.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   rd, wmask, addr, din    CPU request (rd + nonzero wmask counts as a write)
//   flush                   pulse: invalidate every line
//   dout, busy              CPU read data / request in progress
//   mem_rd, mem_wmask,
//   mem_addr, mem_din       request towards the SDRAM controller
//   mem_dout, mem_busy      response from the SDRAM controller
// -----------------------------------------------------------------------------
module sdram_cache
  import sdram_cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd,
  input  logic [3:0]            wmask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  input  logic                  flush,
  output logic [31:0]           dout,
  output logic                  busy,
  output logic                  mem_rd,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_busy
);

  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int TAG_ENTRY = TAG_BITS + 1;  // {valid, tag}

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  cache_state_e            state_q, state_d;
  logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;
  logic                    flush_pending_q, flush_pending_d;
  logic                    force_miss_q, force_miss_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [31:0]             req_din_q, req_din_d;
  logic [3:0]              req_wmask_q, req_wmask_d;

  logic [31:0]             dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [3:0]              mem_wmask_q, mem_wmask_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_din_q, mem_din_d;

  // ---------------------------------------------------------------------------
  // RAM interface
  // ---------------------------------------------------------------------------
  logic [3:0]              data_we;
  logic [31:0]             data_wdata;
  logic [31:0]             data_rdata;
  logic [0:0]              tag_we;
  logic [INDEX_BITS-1:0]   tag_waddr;
  logic [TAG_ENTRY-1:0]    tag_wdata;
  logic [TAG_ENTRY-1:0]    tag_rdata;
  logic [INDEX_BITS-1:0]   ram_raddr;

  logic [INDEX_BITS-1:0]   cpu_index;
  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]     req_tag;
  logic                    req_accept;
  logic                    req_is_write;
  logic                    tag_hit;

  assign cpu_index = INDEX_BITS'(index_of(MAX_ADDR_WIDTH'(addr), INDEX_BITS));
  assign req_index = INDEX_BITS'(index_of(MAX_ADDR_WIDTH'(req_addr_q), INDEX_BITS));
  assign req_tag   = TAG_BITS'(tag_of(MAX_ADDR_WIDTH'(req_addr_q), INDEX_BITS));

  // A request is only taken while not busy; pulses during busy are ignored.
  assign req_accept   = (rd | (|wmask)) & ~busy_q;
  assign req_is_write = |req_wmask_q;

  // While idle the live CPU address feeds the RAMs so LOOKUP sees the line one
  // cycle later. Once a request is latched (busy) the held copy is used, which
  // covers requests parked during a sweep.
  assign ram_raddr = busy_q ? req_index : cpu_index;

  // After a sweep every line is invalid, but the lookup read may have raced
  // the sweep's last write to the same index; force_miss hides that.
  assign tag_hit = tag_rdata[TAG_BITS] && (tag_rdata[TAG_BITS-1:0] == req_tag)
                   && !force_miss_q;

  sdram_cache_ram #(
    .LANE_W   (8),
    .LANES    (4),
    .ADDR_BITS(INDEX_BITS)
  ) u_data_ram (
    .clk_i  (clk),
    .we_i   (data_we),
    .waddr_i(req_index),
    .wdata_i(data_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(data_rdata)
  );

  sdram_cache_ram #(
    .LANE_W   (TAG_ENTRY),
    .LANES    (1),
    .ADDR_BITS(INDEX_BITS)
  ) u_tag_ram (
    .clk_i  (clk),
    .we_i   (tag_we),
    .waddr_i(tag_waddr),
    .wdata_i(tag_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(tag_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    sweep_idx_d     = sweep_idx_q;
    flush_pending_d = flush_pending_q;
    force_miss_d    = (state_q == ST_SWEEP) || (state_q == ST_FLUSH);
    req_addr_d      = req_addr_q;
    req_din_d       = req_din_q;
    req_wmask_d     = req_wmask_q;
    dout_d          = dout_q;
    busy_d          = busy_q;
    mem_rd_d        = 1'b0;   // mem pulses last exactly one cycle
    mem_wmask_d     = 4'b0000;
    mem_addr_d      = mem_addr_q;
    mem_din_d       = mem_din_q;
    data_we         = 4'b0000;
    data_wdata      = req_din_q;
    tag_we          = 1'b0;
    tag_waddr       = req_index;
    tag_wdata       = {1'b1, req_tag};

    // Requests are latched in any state, including during a sweep.
    if (req_accept) begin
      busy_d      = 1'b1;
      req_addr_d  = addr;
      req_din_d   = din;
      req_wmask_d = wmask;
    end

    // A flush that cannot start right now is remembered.
    if (flush && ((state_q != ST_IDLE) || req_accept)) begin
      flush_pending_d = 1'b1;
    end

    unique case (state_q)
      ST_SWEEP, ST_FLUSH: begin
        tag_we      = 1'b1;
        tag_waddr   = sweep_idx_q;
        tag_wdata   = '0;
        sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
        if (sweep_idx_q == {INDEX_BITS{1'b1}}) begin
          if (busy_q || req_accept) begin
            state_d = ST_LOOKUP;
          end else if (flush_pending_q || flush) begin
            state_d         = ST_FLUSH;
            flush_pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (req_accept) begin
          state_d = ST_LOOKUP;
        end else if (flush || flush_pending_q) begin
          state_d         = ST_FLUSH;
          sweep_idx_d     = '0;
          flush_pending_d = 1'b0;
        end
      end

      ST_LOOKUP: begin
        if (req_is_write) begin
          // Write-through; a hit also updates the cached word, a miss
          // leaves the cache untouched.
          mem_wmask_d = req_wmask_q;
          mem_addr_d  = req_addr_q;
          mem_din_d   = req_din_q;
          if (tag_hit) begin
            data_we = req_wmask_q;
          end
          state_d = ST_WR_ISSUE;
        end else if (tag_hit) begin
          dout_d = data_rdata;
          busy_d = 1'b0;
          if (flush_pending_q || flush) begin
            state_d         = ST_FLUSH;
            sweep_idx_d     = '0;
            flush_pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = req_addr_q;
          state_d    = ST_RD_ISSUE;
        end
      end

      // mem_busy only rises the cycle after the pulse, so it is not looked
      // at in the issue states.
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_WR_ISSUE: state_d = ST_WR_WAIT;

      ST_RD_WAIT: begin
        if (!mem_busy) begin
          dout_d     = mem_dout;
          data_we    = 4'b1111;
          data_wdata = mem_dout;
          tag_we     = 1'b1;
          busy_d     = 1'b0;
          if (flush_pending_q || flush) begin
            state_d         = ST_FLUSH;
            sweep_idx_d     = '0;
            flush_pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WR_WAIT: begin
        if (!mem_busy) begin
          busy_d = 1'b0;
          if (flush_pending_q || flush) begin
            state_d         = ST_FLUSH;
            sweep_idx_d     = '0;
            flush_pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_SWEEP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_SWEEP;
      sweep_idx_q     <= '0;
      flush_pending_q <= 1'b0;
      force_miss_q    <= 1'b0;
      req_addr_q      <= '0;
      req_din_q       <= '0;
      req_wmask_q     <= '0;
      dout_q          <= '0;
      busy_q          <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_wmask_q     <= '0;
      mem_addr_q      <= '0;
      mem_din_q       <= '0;
    end else begin
      state_q         <= state_d;
      sweep_idx_q     <= sweep_idx_d;
      flush_pending_q <= flush_pending_d;
      force_miss_q    <= force_miss_d;
      req_addr_q      <= req_addr_d;
      req_din_q       <= req_din_d;
      req_wmask_q     <= req_wmask_d;
      dout_q          <= dout_d;
      busy_q          <= busy_d;
      mem_rd_q        <= mem_rd_d;
      mem_wmask_q     <= mem_wmask_d;
      mem_addr_q      <= mem_addr_d;
      mem_din_q       <= mem_din_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_sdram_cache.sv
// -----------------------------------------------------------------------------
// tb_sdram_cache
// Directed stimulus against sdram_cache with a behavioural SDRAM controller.
// Each request pushes its expected outcome into a queue; a monitor pops and
// compares when busy falls.
// -----------------------------------------------------------------------------
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd;
  logic [3:0]  wmask;
  logic [24:0] addr;
  logic [31:0] din;
  logic        flush;
  logic [31:0] dout;
  logic        busy;
  logic        mem_rd;
  logic [3:0]  mem_wmask;
  logic [24:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_busy;

  always #5 clk = ~clk;

  sdram_cache #(.INDEX_BITS(8), .ADDR_WIDTH(25)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rd       (rd),
    .wmask    (wmask),
    .addr     (addr),
    .din      (din),
    .flush    (flush),
    .dout     (dout),
    .busy     (busy),
    .mem_rd   (mem_rd),
    .mem_wmask(mem_wmask),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_busy (mem_busy)
  );

  // ---------------------------------------------------------------------------
  // Behavioural SDRAM controller: busy rises the cycle after a pulse, stays
  // high 3 cycles, read data valid in the first cycle busy is low again.
  // Unwritten words read as 0x5A5A0000 | addr[15:0]; word 0x100 = 0xDEADBEEF.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_model [0:(1<<17)-1];
  int          lat_cnt;
  logic        pend_rd;
  logic [24:0] pend_addr;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < (1 << 17); i++) mem_model[i] = 32'h5A5A0000 | {16'h0, 14'(i), 2'b00};
    mem_model[17'h00040] = 32'hDEADBEEF;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_busy <= 1'b0;
      lat_cnt  <= 0;
      mem_dout <= '0;
      pend_rd  <= 1'b0;
      pend_addr <= '0;
    end else if (mem_rd || (mem_wmask != 4'b0)) begin
      mem_busy  <= 1'b1;
      lat_cnt   <= 3;
      pend_rd   <= mem_rd && (mem_wmask == 4'b0);
      pend_addr <= mem_addr;
      if (mem_wmask != 4'b0)
        mem_model[mem_addr[18:2]] <= merge(mem_model[mem_addr[18:2]], mem_din, mem_wmask);
    end else if (lat_cnt > 1) begin
      lat_cnt <= lat_cnt - 1;
    end else if (lat_cnt == 1) begin
      lat_cnt  <= 0;
      mem_busy <= 1'b0;
      if (pend_rd) mem_dout <= mem_model[pend_addr[18:2]];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] dout;
    int          n_rd;        // mem_rd pulses expected during the request
    int          n_wr;        // mem_wmask pulses expected
    int          busy_exact;  // 0 = don't care
    int          busy_min;    // 0 = don't care
    logic [3:0]  wm;
    logic [24:0] maddr;
    logic [31:0] mdin;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic exp_t mk(input string n, input bit r, input logic [31:0] d,
                              input int nr, input int nw, input int be, input int bm,
                              input logic [3:0] w, input logic [24:0] ma, input logic [31:0] md);
    exp_t e;
    e.name = n; e.is_rd = r; e.dout = d; e.n_rd = nr; e.n_wr = nw;
    e.busy_exact = be; e.busy_min = bm; e.wm = w; e.maddr = ma; e.mdin = md;
    return e;
  endfunction

  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", n, act, req);
    end
  endtask

  // Monitor: counts activity per request and compares when busy falls.
  initial begin : monitor
    int          busy_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        busy_prev = 1'b0;
    logic [3:0]  last_wm = '0;
    logic [24:0] last_ma = '0;
    logic [31:0] last_md = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; busy_prev = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (mem_rd) begin rd_cnt++; last_ma = mem_addr; end
        if (mem_wmask != 4'b0) begin
          wr_cnt++; last_wm = mem_wmask; last_ma = mem_addr; last_md = mem_din;
        end
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_completion: got completion, required none");
          end else begin
            e = exp_q.pop_front();
            $display("txn %s: dout=0x%08h busy_cycles=%0d mem_rd=%0d mem_wr=%0d",
                     e.name, dout, busy_cnt, rd_cnt, wr_cnt);
            if (e.is_rd) check32({e.name, "_dout"}, dout, e.dout);
            check32({e.name, "_mem_rd_pulses"}, 32'(rd_cnt), 32'(e.n_rd));
            check32({e.name, "_mem_wr_pulses"}, 32'(wr_cnt), 32'(e.n_wr));
            if (e.busy_exact > 0)
              check32({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy_exact));
            if (e.busy_min > 0) begin
              checks++;
              if (busy_cnt < e.busy_min) begin
                fails++;
                $display("FAIL %s_busy_min: got %0d cycles, required >= %0d",
                         e.name, busy_cnt, e.busy_min);
              end
            end
            if (e.n_wr > 0) begin
              check32({e.name, "_mem_wmask"}, 32'(last_wm), 32'(e.wm));
              check32({e.name, "_mem_din"}, last_md, e.mdin);
            end
            if (e.n_rd + e.n_wr > 0) check32({e.name, "_mem_addr"}, 32'(last_ma), 32'(e.maddr));
          end
          busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string who);
    int n = 0;
    while (busy !== 1'b0) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        checks++; fails++;
        $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", who, n);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "busy never fell");
      end
    end
  endtask

  task automatic issue(input logic r, input logic [3:0] wm, input logic [24:0] a,
                       input logic [31:0] d, input bit track, input exp_t e);
    wait_idle(e.name);
    if (track) exp_q.push_back(e);
    rd = r; wmask = wm; addr = a; din = d;
    @(posedge clk); #1;
    rd = 1'b0; wmask = 4'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_dout"},      dout,              32'h0);
    check32({tag, "_busy"},      32'(busy),         32'h0);
    check32({tag, "_mem_rd"},    32'(mem_rd),       32'h0);
    check32({tag, "_mem_wmask"}, 32'(mem_wmask),    32'h0);
    check32({tag, "_mem_addr"},  32'(mem_addr),     32'h0);
    check32({tag, "_mem_din"},   mem_din,           32'h0);
  endtask

  exp_t none;

  initial begin
    none = mk("untracked", 1'b0, '0, 0, 0, 0, 0, '0, '0, '0);
    rd = 1'b0; wmask = '0; addr = '0; din = '0; flush = 1'b0; resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    resetn = 1'b1;

    // 1. Sweep after reset: idle, then a read parked until the sweep ends.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check32("t1_busy_low_in_sweep", 32'(busy), 32'h0);
    end
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t1_parked_read", 1'b1, 32'hDEADBEEF, 1, 0, 0, 250, '0, 25'h0000100, '0));
    wait_idle("t1");

    // Reset in the middle of a miss: outputs drop at once.
    issue(1'b1, 4'h0, 25'h0000400, '0, 1'b0, none);
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #2;
    check_reset_outputs("rst_midop");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (260) begin @(posedge clk); #1; end
    check32("rst_midop_idle_after_sweep", 32'(busy), 32'h0);

    // 2. Cold miss, then hit.
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t2_cold_read", 1'b1, 32'hDEADBEEF, 1, 0, 6, 0, '0, 25'h0000100, '0));
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t2_hit_read", 1'b1, 32'hDEADBEEF, 0, 0, 1, 0, '0, '0, '0));

    // 3. Partial write hit, then hit with merged data.
    issue(1'b0, 4'b0011, 25'h0000100, 32'h12345678, 1'b1,
          mk("t3_write_hit", 1'b0, '0, 0, 1, 6, 0, 4'b0011, 25'h0000100, 32'h12345678));
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t3_read_merged", 1'b1, 32'hDEAD5678, 0, 0, 1, 0, '0, '0, '0));

    // 4. Write miss does not allocate.
    issue(1'b0, 4'hF, 25'h0000400, 32'h0BADF00D, 1'b1,
          mk("t4_write_miss", 1'b0, '0, 0, 1, 6, 0, 4'hF, 25'h0000400, 32'h0BADF00D));
    issue(1'b1, 4'h0, 25'h0000400, '0, 1'b1,
          mk("t4_read_after_wmiss", 1'b1, 32'h0BADF00D, 1, 0, 6, 0, '0, 25'h0000400, '0));

    // 5. Two addresses sharing index 0x40 evict each other.
    issue(1'b1, 4'h0, 25'h0040100, '0, 1'b1,
          mk("t5_alias_a", 1'b1, 32'h5A5A0100, 1, 0, 6, 0, '0, 25'h0040100, '0));
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t5_alias_b", 1'b1, 32'hDEAD5678, 1, 0, 6, 0, '0, 25'h0000100, '0));
    issue(1'b1, 4'h0, 25'h0040100, '0, 1'b1,
          mk("t5_alias_a_again", 1'b1, 32'h5A5A0100, 1, 0, 6, 0, '0, 25'h0040100, '0));

    // 6. Flush pulse during RD_WAIT: read completes, then a full sweep.
    issue(1'b1, 4'h0, 25'h0000800, '0, 1'b1,
          mk("t6_read_during_flush", 1'b1, 32'h5A5A0800, 1, 0, 6, 0, '0, 25'h0000800, '0));
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t6_read_after_flush", 1'b1, 32'hDEAD5678, 1, 0, 0, 250, '0, 25'h0000100, '0));
    // rd together with a full wmask is a write.
    issue(1'b1, 4'hF, 25'h0000100, 32'hCAFEF00D, 1'b1,
          mk("t6_rd_plus_wmask", 1'b0, '0, 0, 1, 6, 0, 4'hF, 25'h0000100, 32'hCAFEF00D));
    issue(1'b1, 4'h0, 25'h0000100, '0, 1'b1,
          mk("t6_read_written", 1'b1, 32'hCAFEF00D, 0, 0, 1, 0, '0, '0, '0));

    wait_idle("final");
    repeat (3) begin @(posedge clk); #1; end
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
